// File: rtl/mem_dbus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common (package)
// Description : Data-bus request/response types and access-size encoding
//               shared by the MEM-stage data-bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package common;

    typedef logic [1:0] msize_t;

    localparam msize_t c_msize_byte  = 2'd0;
    localparam msize_t c_msize_half  = 2'd1;
    localparam msize_t c_msize_word  = 2'd2;
    localparam msize_t c_msize_dword = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Byte lanes covered by an access of the given size at offset 0.
    function automatic logic [7:0] size_lanes(input msize_t size);
        logic [7:0] lanes;
        case (size)
            c_msize_byte: lanes = 8'h01;
            c_msize_half: lanes = 8'h03;
            c_msize_word: lanes = 8'h0F;
            default:      lanes = 8'hFF;
        endcase
        return lanes;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_align_mask(input msize_t size);
        logic [2:0] mask;
        case (size)
            c_msize_byte: mask = 3'b000;
            c_msize_half: mask = 3'b001;
            c_msize_word: mask = 3'b011;
            default:      mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dbus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_dbus_ctrl_if
// Description : MEM-stage side and data-bus side signals of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_dbus_ctrl_if;
    import common::*;

    logic        start;
    logic        is_store;
    logic [63:0] addr;
    logic [63:0] wdata;
    msize_t      msize;
    logic        is_unsigned;
    logic        Iwait;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic [63:0] rdata;
    logic        Dwait;
    logic        misalign;

    modport master (
        input  start, is_store, addr, wdata, msize, is_unsigned, Iwait, dresp,
        output dreq, rdata, Dwait, misalign
    );

    modport slave (
        output start, is_store, addr, wdata, msize, is_unsigned, Iwait, dresp,
        input  dreq, rdata, Dwait, misalign
    );

endinterface
`default_nettype wire

// File: rtl/mem_dbus_ctrl_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Combinational byte-lane alignment. Towards the bus it shifts
//               store data into its lanes; from the bus it extracts and
//               sign/zero-extends the load result. Strobe covers store lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align
    import common::*;
(
    input  logic [2:0]  i_offset,
    input  msize_t      i_size,
    input  logic        i_is_store,
    input  logic        i_is_unsigned,
    input  logic        i_to_bus,
    input  logic [63:0] i_data,
    output logic [7:0]  o_strobe,
    output logic [63:0] o_data
);

    logic [5:0]  w_shift;
    logic [63:0] w_right;
    logic [63:0] w_ext;

    always_comb begin
        w_shift  = {i_offset, 3'b000};
        w_right  = i_data >> w_shift;
        o_strobe = i_is_store ? (size_lanes(i_size) << i_offset) : 8'h00;

        case (i_size)
            c_msize_byte: w_ext = i_is_unsigned ? {56'd0, w_right[7:0]}
                                                : {{56{w_right[7]}}, w_right[7:0]};
            c_msize_half: w_ext = i_is_unsigned ? {48'd0, w_right[15:0]}
                                                : {{48{w_right[15]}}, w_right[15:0]};
            c_msize_word: w_ext = i_is_unsigned ? {32'd0, w_right[31:0]}
                                                : {{32{w_right[31]}}, w_right[31:0]};
            default:      w_ext = w_right;
        endcase

        // A store has no load result, so the response side yields zero.
        if (i_to_bus) begin
            o_data = i_data << w_shift;
        end else if (i_is_store) begin
            o_data = 64'd0;
        end else begin
            o_data = w_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_dbus_ctrl
// Description : MEM-stage data-bus controller: issues one request per memory
//               instruction, stalls the pipeline until data_ok, then holds
//               the load result until fetch releases. Optional macro
//               DBUS_MISALIGN_CHECK_EN suppresses misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dbus_ctrl
    import common::*;
(
    input  logic            clk,
    input  logic            reset,
    mem_dbus_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_addr;
    msize_t      r_msize;
    logic        r_is_store;
    logic        r_is_unsigned;
    logic [63:0] r_wdata_al;
    logic [63:0] r_rdata;

    logic        w_misaligned;
    logic        w_in_wait;
    logic        w_issue;
    logic        w_valid;
    logic        w_data_ok;

    logic [63:0] w_sel_addr;
    msize_t      w_sel_msize;
    logic        w_sel_is_store;
    logic        w_sel_is_unsigned;

    logic [7:0]  w_req_strobe;
    logic [63:0] w_req_data;
    logic [7:0]  w_rsp_strobe;
    logic [63:0] w_rsp_data;
    dbus_req_t   w_dreq;

`ifdef DBUS_MISALIGN_CHECK_EN
    assign w_misaligned = (bus.addr[2:0] & size_align_mask(bus.msize)) != 3'd0;
`else
    assign w_misaligned = 1'b0;
`endif

    // Issue cycle uses the live instruction; WAIT replays the latched copy.
    always_comb begin
        w_in_wait         = (r_state == S_WAIT);
        w_sel_addr        = w_in_wait ? r_addr        : bus.addr;
        w_sel_msize       = w_in_wait ? r_msize       : bus.msize;
        w_sel_is_store    = w_in_wait ? r_is_store    : bus.is_store;
        w_sel_is_unsigned = w_in_wait ? r_is_unsigned : bus.is_unsigned;
    end

    mem_align u_req_align (
        .i_offset      (bus.addr[2:0]),
        .i_size        (bus.msize),
        .i_is_store    (bus.is_store),
        .i_is_unsigned (bus.is_unsigned),
        .i_to_bus      (1'b1),
        .i_data        (bus.wdata),
        .o_strobe      (w_req_strobe),
        .o_data        (w_req_data)
    );

    mem_align u_rsp_align (
        .i_offset      (w_sel_addr[2:0]),
        .i_size        (w_sel_msize),
        .i_is_store    (w_sel_is_store),
        .i_is_unsigned (w_sel_is_unsigned),
        .i_to_bus      (1'b0),
        .i_data        (bus.dresp.data),
        .o_strobe      (w_rsp_strobe),
        .o_data        (w_rsp_data)
    );

    // data_ok only counts while a request is actually on the bus, so a late
    // response for an abandoned request cannot reach the result latch.
    always_comb begin
        w_issue     = !reset && (r_state == S_IDLE) && bus.start && !w_misaligned;
        w_valid     = w_issue || (!reset && w_in_wait);
        w_data_ok   = w_valid && bus.dresp.data_ok;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = w_data_ok ? S_HOLD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_data_ok) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.Iwait) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_dreq        = '0;
        w_dreq.valid  = w_valid;
        w_dreq.addr   = w_sel_addr;
        w_dreq.size   = w_sel_msize;
        w_dreq.strobe = w_valid ? (w_in_wait ? w_rsp_strobe : w_req_strobe) : 8'h00;
        w_dreq.data   = w_in_wait ? r_wdata_al : w_req_data;
    end

    assign bus.dreq     = w_dreq;
    assign bus.Dwait    = w_valid;
    assign bus.misalign = !reset && (r_state == S_IDLE) && bus.start && w_misaligned;
    assign bus.rdata    = reset ? 64'd0 : r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= 64'd0;
            r_msize       <= c_msize_byte;
            r_is_store    <= 1'b0;
            r_is_unsigned <= 1'b0;
            r_wdata_al    <= 64'd0;
            r_rdata       <= 64'd0;
        end else begin
            if (w_issue) begin
                r_addr        <= bus.addr;
                r_msize       <= bus.msize;
                r_is_store    <= bus.is_store;
                r_is_unsigned <= bus.is_unsigned;
                r_wdata_al    <= w_req_data;
            end
            if (w_data_ok) begin
                r_rdata <= w_rsp_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dbus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dbus_ctrl
// Description : Self-checking bench for mem_dbus_ctrl with directed scenarios
//               and randomized transactions against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dbus_ctrl;
    import common::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_dbus_ctrl_if bus ();

    mem_dbus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic logic [7:0] m_strobe(logic st, logic [2:0] off, logic [1:0] sz);
        logic [7:0] s = 8'h00;
        int n = 1 << sz;
        if (st) for (int i = 0; i < 8; i++) if (i >= int'(off) && i < int'(off) + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(logic [63:0] wd, logic [2:0] off);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++) if (i + int'(off) < 8) v[(i + int'(off)) * 8 +: 8] = wd[i * 8 +: 8];
        return v;
    endfunction

    function automatic logic [63:0] m_load(logic [63:0] rd, logic [2:0] off, logic [1:0] sz,
                                           logic uns, logic st);
        logic [63:0] v = 64'd0;
        int n = 1 << sz;
        if (st) return 64'd0;
        for (int k = 0; k < n; k++) if (int'(off) + k < 8) v[k * 8 +: 8] = rd[(int'(off) + k) * 8 +: 8];
        if (!uns && n < 8 && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    task automatic drive_idle();
        bus.start       = 1'b0;
        bus.is_store    = 1'b0;
        bus.addr        = 64'd0;
        bus.wdata       = 64'd0;
        bus.msize       = 2'd0;
        bus.is_unsigned = 1'b0;
        bus.Iwait       = 1'b0;
        bus.dresp       = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        bus.start = 1'b1; bus.is_store = 1'b1; bus.addr = 64'h8000_0000; bus.msize = 2'd3;
        #1;
        checks++;
        if (bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0 || bus.misalign !== 1'b0 || bus.dreq.strobe !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs valid=%b Dwait=%b misalign=%b strobe=%h required all 0",
                     bus.dreq.valid, bus.Dwait, bus.misalign, bus.dreq.strobe);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.rdata !== 64'd0) begin
            errors++; $display("FAIL reset_rdata got %h required 0", bus.rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        #1;
        checks++;
        if (bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset valid=%b Dwait=%b required 0", bus.dreq.valid, bus.Dwait);
        end
    endtask

    task automatic test_load_word();
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.is_store = 1'b0; bus.addr = 64'h8000_0004;
            bus.msize = 2'd2; bus.is_unsigned = 1'b0; bus.Iwait = 1'b0;
            bus.dresp.data_ok = (c == 3);
            bus.dresp.data    = (c == 3) ? 64'h8000_0000_0000_0000 : 64'h1234_5678_9ABC_DEF0;
            #1;
            checks++;
            if (bus.Dwait !== (c <= 3) || bus.dreq.valid !== (c <= 3)) begin
                errors++;
                $display("FAIL load_word_cycle%0d Dwait=%b valid=%b required %b", c, bus.Dwait, bus.dreq.valid, c <= 3);
            end
        end
        checks++;
        if (bus.rdata !== 64'hFFFF_FFFF_8000_0000) begin
            errors++; $display("FAIL load_word_rdata got %h required ffffffff80000000", bus.rdata);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_store_byte();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.is_store = 1'b1; bus.Iwait = 1'b0;
            if (c == 0) begin
                bus.addr = 64'h8000_0003; bus.wdata = 64'hAB; bus.msize = 2'd0;
            end else begin
                bus.addr = {$urandom, $urandom}; bus.wdata = {$urandom, $urandom}; bus.msize = 2'($urandom);
            end
            bus.dresp.addr_ok = (c == 2);
            bus.dresp.data_ok = (c == 6);
            bus.dresp.data    = {$urandom, $urandom};
            #1;
            checks++;
            if (c <= 6 && (bus.dreq.valid !== 1'b1 || bus.dreq.strobe !== 8'h08 ||
                           bus.dreq.data !== 64'h0000_0000_AB00_0000 || bus.dreq.addr !== 64'h8000_0003 ||
                           bus.dreq.size !== 2'd0 || bus.Dwait !== 1'b1)) begin
                errors++;
                $display("FAIL store_byte_cycle%0d valid=%b strobe=%h data=%h addr=%h size=%0d required 1/08/00000000ab000000/80000003/0",
                         c, bus.dreq.valid, bus.dreq.strobe, bus.dreq.data, bus.dreq.addr, bus.dreq.size);
            end
            if (c == 7 && (bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0 || bus.rdata !== 64'd0)) begin
                errors++;
                $display("FAIL store_byte_hold valid=%b Dwait=%b rdata=%h required 0/0/0", bus.dreq.valid, bus.Dwait, bus.rdata);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_same_cycle_hold();
        int nreq = 0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            bus.start = (c <= 4); bus.is_store = 1'b0; bus.is_unsigned = 1'b0;
            bus.msize = 2'd3;
            bus.addr  = (c < 4) ? 64'h8000_0008 : 64'h8000_0010;
            bus.Iwait = (c <= 2);
            bus.dresp.addr_ok = 1'b1;
            bus.dresp.data_ok = 1'b1;
            bus.dresp.data    = (c == 0) ? 64'h0123_4567_89AB_CDEF :
                                (c == 4) ? 64'hFEDC_BA98_7654_3210 : {$urandom, $urandom};
            #1;
            if (c <= 3 && bus.dreq.valid === 1'b1) nreq++;
            if (c >= 1 && c <= 3) begin
                checks++;
                if (bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0 || bus.rdata !== 64'h0123_4567_89AB_CDEF) begin
                    errors++;
                    $display("FAIL hold_cycle%0d valid=%b Dwait=%b rdata=%h required 0/0/0123456789abcdef",
                             c, bus.dreq.valid, bus.Dwait, bus.rdata);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.dreq.valid !== 1'b1) begin
                    errors++; $display("FAIL hold_exit_reissue valid=%b required 1", bus.dreq.valid);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.rdata !== 64'hFEDC_BA98_7654_3210) begin
                    errors++; $display("FAIL hold_second_rdata got %h required fedcba9876543210", bus.rdata);
                end
            end
        end
        checks++;
        if (nreq !== 1) begin
            errors++; $display("FAIL hold_request_count got %0d required 1", nreq);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_in_wait();
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            drive_idle();
            reset = (c == 2);
            if (c <= 1 || c >= 5) begin
                bus.start = 1'b1; bus.msize = 2'd0; bus.is_unsigned = 1'b1; bus.addr = 64'h8000_0005;
            end
            bus.dresp.data_ok = (c == 4) || (c == 6);
            bus.dresp.data    = (c == 6) ? 64'h0000_7700_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
            #1;
            if (c == 2) begin
                checks++;
                if (bus.dreq.valid !== 1'b0 || bus.rdata !== 64'd0 || bus.Dwait !== 1'b0) begin
                    errors++; $display("FAIL rst_wait_during valid=%b Dwait=%b rdata=%h required 0/0/0",
                                       bus.dreq.valid, bus.Dwait, bus.rdata);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0) begin
                    errors++; $display("FAIL rst_wait_late_dataok valid=%b Dwait=%b required 0/0", bus.dreq.valid, bus.Dwait);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.rdata !== 64'd0 || bus.dreq.valid !== 1'b1) begin
                    errors++; $display("FAIL rst_wait_after rdata=%h valid=%b required 0/1", bus.rdata, bus.dreq.valid);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.rdata !== 64'h77) begin
                    errors++; $display("FAIL rst_wait_next_load rdata=%h required 77", bus.rdata);
                end
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_misalign();
        @(negedge clk);
        drive_idle();
        bus.start = 1'b1; bus.msize = 2'd1; bus.addr = 64'h8000_0001; bus.is_unsigned = 1'b0;
        bus.dresp.data_ok = 1'b1; bus.dresp.data = 64'h0000_0000_00C3_A500;
        #1;
`ifdef DBUS_MISALIGN_CHECK_EN
        checks++;
        if (bus.misalign !== 1'b1 || bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0) begin
            errors++; $display("FAIL misalign_flag misalign=%b valid=%b Dwait=%b required 1/0/0",
                               bus.misalign, bus.dreq.valid, bus.Dwait);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (bus.misalign !== 1'b0 || bus.dreq.valid !== 1'b0 || bus.rdata !== 64'd0) begin
            errors++; $display("FAIL misalign_after misalign=%b valid=%b rdata=%h required 0/0/0",
                               bus.misalign, bus.dreq.valid, bus.rdata);
        end
`else
        checks++;
        if (bus.misalign !== 1'b0 || bus.dreq.valid !== 1'b1 || bus.dreq.size !== 2'd1 || bus.dreq.strobe !== 8'h00) begin
            errors++; $display("FAIL misalign_issue misalign=%b valid=%b size=%0d strobe=%h required 0/1/1/00",
                               bus.misalign, bus.dreq.valid, bus.dreq.size, bus.dreq.strobe);
        end
        @(negedge clk);
        bus.dresp = '0;
        #1;
        checks++;
        if (bus.rdata !== 64'hFFFF_FFFF_FFFF_C3A5 || bus.dreq.valid !== 1'b0) begin
            errors++; $display("FAIL misalign_rdata got %h valid=%b required ffffffffffffc3a5/0", bus.rdata, bus.dreq.valid);
        end
`endif
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_random();
        logic        st, uns, mis;
        logic [1:0]  sz;
        logic [63:0] a, wd, rd, e_rd, e_wd;
        logic [7:0]  e_strb;
        int          lat, hold;
        for (int t = 0; t < 60; t++) begin
            st = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
            a = {$urandom, $urandom}; wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
            lat = $urandom_range(0, 3); hold = $urandom_range(0, 2);
            e_strb = m_strobe(st, a[2:0], sz);
            e_wd   = m_wdata(wd, a[2:0]);
            e_rd   = m_load(rd, a[2:0], sz, uns, st);
`ifdef DBUS_MISALIGN_CHECK_EN
            mis = (a % (64'd1 << sz)) != 64'd0;
`else
            mis = 1'b0;
`endif
            if (mis) begin
                @(negedge clk);
                bus.start = 1'b1; bus.is_store = st; bus.addr = a; bus.wdata = wd; bus.msize = sz; bus.is_unsigned = uns;
                #1;
                checks++;
                if (bus.misalign !== 1'b1 || bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d_misalign misalign=%b valid=%b Dwait=%b required 1/0/0",
                                       t, bus.misalign, bus.dreq.valid, bus.Dwait);
                end
            end else begin
                for (int c = 0; c <= lat; c++) begin
                    @(negedge clk);
                    bus.start = 1'b1; bus.is_store = st; bus.addr = a; bus.wdata = wd; bus.msize = sz;
                    bus.is_unsigned = uns; bus.Iwait = 1'($urandom);
                    bus.dresp.addr_ok = (c == 0);
                    bus.dresp.data_ok = (c == lat);
                    bus.dresp.data    = (c == lat) ? rd : {$urandom, $urandom};
                    #1;
                    checks++;
                    if (bus.dreq.valid !== 1'b1 || bus.Dwait !== 1'b1 || bus.misalign !== 1'b0 ||
                        bus.dreq.addr !== a || bus.dreq.size !== sz || bus.dreq.strobe !== e_strb || bus.dreq.data !== e_wd) begin
                        errors++;
                        $display("FAIL rnd%0d_req_c%0d valid=%b Dwait=%b addr=%h size=%0d strobe=%h data=%h required 1/1/%h/%0d/%h/%h",
                                 t, c, bus.dreq.valid, bus.Dwait, bus.dreq.addr, bus.dreq.size, bus.dreq.strobe,
                                 bus.dreq.data, a, sz, e_strb, e_wd);
                    end
                end
                for (int j = 0; j <= hold; j++) begin
                    @(negedge clk);
                    bus.Iwait = (j < hold);
                    bus.dresp.data_ok = 1'($urandom);
                    bus.dresp.data    = {$urandom, $urandom};
                    #1;
                    checks++;
                    if (bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0 || bus.rdata !== e_rd) begin
                        errors++;
                        $display("FAIL rnd%0d_hold_j%0d valid=%b Dwait=%b rdata=%h required 0/0/%h",
                                 t, j, bus.dreq.valid, bus.Dwait, bus.rdata, e_rd);
                    end
                end
            end
            @(negedge clk);
            drive_idle();
            bus.dresp.data_ok = 1'($urandom);
            bus.dresp.data    = {$urandom, $urandom};
            #1;
            checks++;
            if (bus.dreq.valid !== 1'b0 || bus.Dwait !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_gap valid=%b Dwait=%b required 0/0", t, bus.dreq.valid, bus.Dwait);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_load_word();
        test_store_byte();
        test_same_cycle_hold();
        test_reset_in_wait();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_dbus_ctrl.md
MEM_DBUS_CTRL -- requirements
Module: mem_dbus_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  pipeline clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  MEM stage holds a valid, non-bubble memory instruction.
REQ-004 SHALL have port: is_store  in  1  1 = store, 0 = load; meaningful only with start.
REQ-005 SHALL have port: addr  in  64  byte address of the access.
REQ-006 SHALL have port: wdata  in  64  store data, right-aligned.
REQ-007 SHALL have port: msize  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-008 SHALL have port: is_unsigned  in  1  zero-extend the load result when 1, sign-extend when 0.
REQ-009 SHALL have port: Iwait  in  1  fetch stall; the pipeline does not advance while high.
REQ-010 SHALL have port: dreq  out  dbus_req_t  data-bus request: valid, addr, size, strobe, data.
REQ-011 SHALL have port: dresp  in  dbus_resp_t  data-bus response: addr_ok, data_ok, data[63:0].
REQ-012 SHALL have port: rdata  out  64  aligned and extended load result.
REQ-013 SHALL have port: Dwait  out  1  data stall; the MEM/WB register inserts a bubble while high.
REQ-014 SHALL have port: misalign  out  1  misaligned-access flag (see Configuration).

Function
REQ-015 SHALL implement three states: IDLE, WAIT and HOLD.
REQ-016 IDLE: when start is high (and the access is not suppressed), SHALL drive dreq.valid=1 combinationally, SHALL latch addr, msize, is_store, is_unsigned and the aligned data, and SHALL move to WAIT.
REQ-017 WAIT: SHALL hold dreq.valid=1 with all fields stable and taken from the latched copy until dresp.data_ok=1; a cycle with addr_ok=1 and data_ok=0 SHALL NOT change the request.
REQ-018 WAIT with data_ok=1: SHALL latch the aligned load result, drop dreq.valid the next cycle, and move to HOLD; this also applies when addr_ok and data_ok arrive in the same cycle.
REQ-019 HOLD: SHALL keep dreq.valid=0 and present rdata from the latch; SHALL return to IDLE in the cycle where Iwait=0 and SHALL remain in HOLD while Iwait=1, so each instruction issues exactly one request.
REQ-020 Dwait SHALL equal (IDLE and start and not suppressed) or WAIT; Dwait SHALL be 0 in HOLD.
REQ-021 Minimum latency SHALL be: start at cycle 0, data_ok at cycle 0 or later, Dwait low one cycle after data_ok.
REQ-022 dreq.size SHALL equal msize; dreq.addr SHALL equal the full addr.
REQ-023 dreq.strobe SHALL be 0 for loads; for stores it SHALL be {01, 03, 0F, FF}[msize] shifted left by addr[2:0]; dreq.data SHALL be wdata shifted left by 8*addr[2:0].
REQ-024 rdata SHALL be dresp.data shifted right by 8*addr[2:0], truncated to msize, then sign- or zero-extended per is_unsigned; for stores rdata SHALL be 0.
REQ-025 dresp values arriving in IDLE or HOLD SHALL be ignored.

Reset
REQ-026 While reset is high, the block SHALL enter IDLE, drive dreq.valid=0, Dwait=0, misalign=0 and strobe=0, and clear rdata and all latches to 0.
REQ-027 A reset asserted in WAIT SHALL abandon the request; a data_ok for it arriving after reset SHALL be ignored under REQ-025.

Configuration
REQ-028 Macro DBUS_MISALIGN_CHECK_EN: when defined, an access with addr not aligned to 2^msize bytes SHALL issue no request, SHALL assert misalign=1 and Dwait=0 combinationally, and SHALL leave the state in IDLE.
REQ-029 Without DBUS_MISALIGN_CHECK_EN, misalign SHALL be tied to 0 and every access SHALL be issued unchanged.

Structure
REQ-030 dbus_req_t, dbus_resp_t and the msize encoding SHALL live in package common; the state enum SHALL be local to the module.
REQ-031 Strobe, data alignment and load extension SHALL be a combinational sub-module, mem_align, instantiated once for the request path and once for the response path.

Verification
REQ-032 Load word, unsigned=0, addr=0x80000004, data_ok on cycle 3 with data=0x80000000_00000000 -> Dwait high on cycles 0-3, rdata=0xFFFFFFFF_80000000, dreq.valid low from cycle 4.
REQ-033 Store byte wdata=0xAB, addr=0x80000003 -> strobe=0x08 and data=0x00000000_AB000000, stable through 5 wait cycles.
REQ-034 addr_ok and data_ok both in cycle 0, load dword with Iwait=1 for 3 cycles -> HOLD for 3 cycles, dreq.valid=0, exactly one request issued.
REQ-035 Reset in cycle 2 of WAIT, data_ok in cycle 4 -> state IDLE, rdata=0, no HOLD entered.
REQ-036 With DBUS_MISALIGN_CHECK_EN defined, load half at addr=0x80000001 -> misalign=1, dreq.valid=0, Dwait=0; without the macro -> request issued with size=1.
